integrate_dump: RTL and testbench

- Integrate-and-dump accumulator, one stage upstream of convert.
- Sums ACC_LEN valid fixed-point samples into a wider word with the same binary point.
- Presents each dump with a one-cycle valid strobe; convert then narrows the result to the downstream format.
- Used for spectral/power integration ahead of requantisation.

---
 rtl/integrate_dump.sv | 132 +++++++++++++
 tb/tb_integrate_dump.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/integrate_dump.sv
// integrate_dump: integrate-and-dump accumulator ahead of requantisation.
// Sums ACC_LEN valid samples into an N_BITS_OUT word (same binary point) and
// presents each dump with a one-cycle dout_valid strobe.
// Optional build macro INTEGRATE_DUMP_OVF_EN adds a per-frame sticky overflow
// flag on output port dout_ovf.
module integrate_dump #(
   parameter int N_BITS_IN  = 4,
   parameter int BIN_PT_IN  = 4,
   parameter int N_BITS_OUT = 6,
   parameter int ACC_LEN    = 4,
   parameter int SIGNED     = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sync,
   input  logic [N_BITS_IN-1:0]  din,
   input  logic                  din_valid,
   output logic [N_BITS_OUT-1:0] dout,
   output logic                  dout_valid
`ifdef INTEGRATE_DUMP_OVF_EN
   ,
   output logic                  dout_ovf
`endif
);

   localparam int unsigned CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
   localparam int unsigned MSB = N_BITS_OUT - 1;

   // Elaboration-time parameter sanity checks
   if (N_BITS_OUT < N_BITS_IN) begin : g_bad_width
      $error("integrate_dump: N_BITS_OUT must be >= N_BITS_IN");
   end
   if (ACC_LEN < 1) begin : g_bad_len
      $error("integrate_dump: ACC_LEN must be >= 1");
   end
   if (BIN_PT_IN < 0) begin : g_bad_binpt
      $error("integrate_dump: BIN_PT_IN must be >= 0");
   end

   logic [N_BITS_OUT-1:0] acc;
   logic [N_BITS_OUT-1:0] acc_nxt;
   logic [CNT_W-1:0]      count;
   logic [CNT_W-1:0]      count_nxt;
   logic [N_BITS_OUT-1:0] ext;
   logic [N_BITS_OUT-1:0] base;
   logic [N_BITS_OUT-1:0] sum;
   logic                  first_c;
   logic                  last_c;

   // Widen the input sample to the accumulator width (binary point unchanged)
   if (SIGNED != 0) begin : g_sext
      assign ext = N_BITS_OUT'($signed(din));
   end else begin : g_zext
      assign ext = N_BITS_OUT'(din);
   end

`ifdef INTEGRATE_DUMP_OVF_EN
   logic ovf_flag;
   logic ovf_flag_nxt;
   logic carry;
   logic add_ovf;
`endif

   // Next-state: frame start restarts the sum from zero, last sample dumps
   always_comb begin
      first_c   = sync | (count == '0);
      base      = first_c ? '0 : acc;
`ifdef INTEGRATE_DUMP_OVF_EN
      {carry, sum} = {1'b0, base} + {1'b0, ext};
`else
      sum       = base + ext;
`endif
      last_c    = din_valid & ((ACC_LEN == 1) | (~sync & (count == CNT_LAST)));
      acc_nxt   = acc;
      count_nxt = count;
      if (din_valid) begin
         acc_nxt = sum;
         if (last_c) begin
            count_nxt = '0;
         end else if (first_c) begin
            count_nxt = CNT_W'(1);
         end else begin
            count_nxt = count + CNT_W'(1);
         end
      end else if (sync) begin
         count_nxt = '0;
      end
   end

`ifdef INTEGRATE_DUMP_OVF_EN
   // Sticky overflow of the current frame; any add out of the output range
   always_comb begin
      add_ovf = (SIGNED != 0) ? ((base[MSB] == ext[MSB]) && (sum[MSB] != base[MSB]))
                              : carry;
      ovf_flag_nxt = ovf_flag;
      if (din_valid) begin
         ovf_flag_nxt = (first_c ? 1'b0 : ovf_flag) | add_ovf;
      end else if (sync) begin
         ovf_flag_nxt = 1'b0;
      end
   end
`endif

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc        <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
`ifdef INTEGRATE_DUMP_OVF_EN
         ovf_flag   <= 1'b0;
         dout_ovf   <= 1'b0;
`endif
      end else begin
         acc        <= acc_nxt;
         count      <= count_nxt;
         dout_valid <= last_c;
         if (last_c) begin
            dout <= sum;
         end
`ifdef INTEGRATE_DUMP_OVF_EN
         ovf_flag <= ovf_flag_nxt;
         if (last_c) begin
            dout_ovf <= ovf_flag_nxt;
         end
`endif
      end
   end

endmodule

// File: tb/tb_integrate_dump.sv
// Testbench for integrate_dump: four configurations share one stimulus stream
// and are checked against a sample-counting reference model, plus a vector
// table and hand-written sequences for the documented corner cases.
module tb_integrate_dump;

   localparam int NDUT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       sync;
   logic [3:0] din;
   logic       din_valid;

   logic [5:0] dout0, dout2, dout3;
   logic [4:0] dout1;
   logic       dv0, dv1, dv2, dv3;
`ifdef INTEGRATE_DUMP_OVF_EN
   logic       ovf0, ovf1, ovf2, ovf3;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state per configuration
   int m_len[NDUT], m_w[NDUT], m_sg[NDUT];
   int m_a[NDUT], m_n[NDUT], m_dout[NDUT], m_valid[NDUT], m_ovf[NDUT], m_dovf[NDUT];

   always #5 clk = ~clk;

   integrate_dump #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(6), .ACC_LEN(4), .SIGNED(0)) u0 (
      .clk(clk), .rst(rst), .sync(sync), .din(din), .din_valid(din_valid),
      .dout(dout0), .dout_valid(dv0)
`ifdef INTEGRATE_DUMP_OVF_EN
      , .dout_ovf(ovf0)
`endif
   );
   integrate_dump #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(5), .ACC_LEN(4), .SIGNED(0)) u1 (
      .clk(clk), .rst(rst), .sync(sync), .din(din), .din_valid(din_valid),
      .dout(dout1), .dout_valid(dv1)
`ifdef INTEGRATE_DUMP_OVF_EN
      , .dout_ovf(ovf1)
`endif
   );
   integrate_dump #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(6), .ACC_LEN(4), .SIGNED(1)) u2 (
      .clk(clk), .rst(rst), .sync(sync), .din(din), .din_valid(din_valid),
      .dout(dout2), .dout_valid(dv2)
`ifdef INTEGRATE_DUMP_OVF_EN
      , .dout_ovf(ovf2)
`endif
   );
   integrate_dump #(.N_BITS_IN(4), .BIN_PT_IN(4), .N_BITS_OUT(6), .ACC_LEN(1), .SIGNED(1)) u3 (
      .clk(clk), .rst(rst), .sync(sync), .din(din), .din_valid(din_valid),
      .dout(dout3), .dout_valid(dv3)
`ifdef INTEGRATE_DUMP_OVF_EN
      , .dout_ovf(ovf3)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_a[k] = 0; m_n[k] = 0; m_dout[k] = 0; m_valid[k] = 0; m_ovf[k] = 0; m_dovf[k] = 0;
      end
   endfunction

   // One clock edge of the reference: exact integer adds, then wrap to width
   function automatic void model_edge(input logic s, input logic v, input logic [3:0] d);
      for (int k = 0; k < NDUT; k++) begin
         int m;
         int x;
         int e;
         int lo;
         int hi;
         m  = 1 << m_w[k];
         x  = (m_sg[k] != 0 && d[3]) ? int'(d) - 16 : int'(d);
         lo = (m_sg[k] != 0) ? -(m / 2) : 0;
         hi = (m_sg[k] != 0) ? (m / 2) - 1 : m - 1;
         m_valid[k] = 0;
         if (v) begin
            if (s || m_n[k] == 0) begin
               m_a[k] = x; m_ovf[k] = 0; m_n[k] = 1;
            end else begin
               e = m_a[k] + x;
               if (e < lo || e > hi) m_ovf[k] = 1;
               e = ((e % m) + m) % m;
               if (m_sg[k] != 0 && e > hi) e = e - m;
               m_a[k] = e;
               m_n[k]++;
            end
            if (m_n[k] == m_len[k]) begin
               m_dout[k]  = ((m_a[k] % m) + m) % m;
               m_valid[k] = 1;
               m_dovf[k]  = m_ovf[k];
               m_n[k]     = 0;
            end
         end else if (s) begin
            m_n[k] = 0;
         end
      end
   endfunction

   task automatic check_all();
      check("u0_dout", int'(dout0), m_dout[0]);
      check("u0_valid", int'(dv0), m_valid[0]);
      check("u1_dout", int'(dout1), m_dout[1]);
      check("u1_valid", int'(dv1), m_valid[1]);
      check("u2_dout", int'(dout2), m_dout[2]);
      check("u2_valid", int'(dv2), m_valid[2]);
      check("u3_dout", int'(dout3), m_dout[3]);
      check("u3_valid", int'(dv3), m_valid[3]);
`ifdef INTEGRATE_DUMP_OVF_EN
      check("u0_ovf", int'(ovf0), m_dovf[0]);
      check("u1_ovf", int'(ovf1), m_dovf[1]);
      check("u2_ovf", int'(ovf2), m_dovf[2]);
      check("u3_ovf", int'(ovf3), m_dovf[3]);
`endif
   endtask

   task automatic step(input logic s, input logic v, input logic [3:0] d);
      sync = s; din_valid = v; din = d;
      @(posedge clk);
      model_edge(s, v, d);
      #1;
      check_all();
   endtask

   typedef struct {
      logic       s;
      logic       v;
      logic [3:0] d;
      logic       ev;
      int         ed;
   } vec_t;

   vec_t tbl[12];

   initial begin
      m_len = '{4, 4, 4, 1};
      m_w   = '{6, 5, 6, 6};
      m_sg  = '{0, 0, 1, 1};

      // Expected u0 (6-bit unsigned, ACC_LEN=4) results after each edge
      tbl[0]  = '{1'b0, 1'b1, 4'hC, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b1, 4'hC, 1'b0, 0};
      tbl[2]  = '{1'b0, 1'b1, 4'hC, 1'b0, 0};
      tbl[3]  = '{1'b0, 1'b1, 4'hC, 1'b1, 48};
      tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 48};
      tbl[5]  = '{1'b0, 1'b1, 4'h1, 1'b0, 48};
      tbl[6]  = '{1'b0, 1'b1, 4'h1, 1'b0, 48};
      tbl[7]  = '{1'b1, 1'b1, 4'h2, 1'b0, 48};
      tbl[8]  = '{1'b0, 1'b1, 4'h2, 1'b0, 48};
      tbl[9]  = '{1'b0, 1'b1, 4'h2, 1'b0, 48};
      tbl[10] = '{1'b0, 1'b1, 4'h2, 1'b1, 8};
      tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 8};

      rst = 1'b1; sync = 1'b0; din_valid = 1'b0; din = 4'h0;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Table: consecutive dump, then discarded partial frame via sync
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].s, tbl[i].v, tbl[i].d);
         check($sformatf("tbl%0d_valid", i), int'(dv0), int'(tbl[i].ev));
         check($sformatf("tbl%0d_dout", i), int'(dout0), tbl[i].ed);
      end

      // Same samples with 3 idle cycles between valids
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 4'hC);
         check("gap_valid", int'(dv0), (i == 3) ? 1 : 0);
         if (i == 3) check("gap_dout", int'(dout0), 48);
         else repeat (3) step(1'b0, 1'b0, 4'h0);
      end
      step(1'b0, 1'b0, 4'h0);
      check("gap_after_valid", int'(dv0), 0);
      check("gap_after_dout", int'(dout0), 48);

      // 5-bit wrap and overflow flag
      step(1'b1, 1'b0, 4'h0);
      repeat (4) step(1'b0, 1'b1, 4'hF);
      check("wrap5_dout", int'(dout1), 28);
      check("wrap5_valid", int'(dv1), 1);
`ifdef INTEGRATE_DUMP_OVF_EN
      check("wrap5_ovf", int'(ovf1), 1);
`endif
      repeat (4) step(1'b0, 1'b1, 4'h1);
      check("nowrap5_dout", int'(dout1), 4);
`ifdef INTEGRATE_DUMP_OVF_EN
      check("nowrap5_ovf", int'(ovf1), 0);
`endif

      // Signed sums
      step(1'b1, 1'b0, 4'h0);
      repeat (4) step(1'b0, 1'b1, 4'h8);
      check("sgn_m32", int'(dout2), 32);
      repeat (4) step(1'b0, 1'b1, 4'hF);
      check("sgn_m4", int'(dout2), 60);

      // Reset mid-frame
      step(1'b1, 1'b0, 4'h0);
      repeat (2) step(1'b0, 1'b1, 4'h4);
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_dout", int'(dout0), 0);
      check("rst_valid", int'(dv0), 0);
      check_all();
      @(negedge clk);
      rst = 1'b0;
      repeat (4) step(1'b0, 1'b1, 4'h4);
      check("post_rst_dout", int'(dout0), 16);
      check("post_rst_valid", int'(dv0), 1);

      // Randomised traffic with occasional sync
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(15) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(1)),
              4'($urandom_range(15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
